// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-outstanding-request bus master that presents
// fetched words (or address-error entries) to IF/ID and follows branch/flush redirects.
module inst_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcp4,
  output logic [31:0] if_inst,
  output logic [4:0]  if_excp,
  output logic        if_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HOLD} state_t;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [4:0]  EXC_NONE  = 5'h00;
  localparam logic [4:0]  EXC_ADEL  = 5'h04;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        pending, pending_nx;
  logic [31:0] pending_target, pending_target_nx;
  logic [31:0] if_pc_nx, if_pcp4_nx, if_inst_nx;
  logic [4:0]  if_excp_nx;
  logic        if_valid_nx;
  logic        aligned;

  assign aligned     = (pc[1:0] == 2'b00);
  assign ibus_req    = rst_n && (state == S_REQ) && aligned;
  assign ibus_addr   = pc;
  assign fetch_stall = ~if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      pending        <= 1'b0;
      pending_target <= 32'h0;
      if_pc          <= 32'h0;
      if_pcp4        <= 32'h0;
      if_inst        <= 32'h0;
      if_excp        <= EXC_NONE;
      if_valid       <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      pending        <= pending_nx;
      pending_target <= pending_target_nx;
      if_pc          <= if_pc_nx;
      if_pcp4        <= if_pcp4_nx;
      if_inst        <= if_inst_nx;
      if_excp        <= if_excp_nx;
      if_valid       <= if_valid_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    pc_nx             = pc;
    pending_nx        = pending;
    pending_target_nx = pending_target;
    if_pc_nx          = if_pc;
    if_pcp4_nx        = if_pcp4;
    if_inst_nx        = if_inst;
    if_excp_nx        = if_excp;
    if_valid_nx       = if_valid;

    if (flush) begin
      // A flush wins over br_flag; an accepted-but-unreturned request must be drained.
      pc_nx       = flush_pc;
      pending_nx  = 1'b0;
      if_valid_nx = 1'b0;
      unique case (state)
        S_REQ:     state_nx = (aligned && ibus_ready) ? S_DISCARD : S_REQ;
        S_WAIT:    state_nx = S_DISCARD;
        S_HOLD:    state_nx = S_REQ;
        S_DISCARD: state_nx = ibus_rvalid ? S_REQ : S_DISCARD;
        default:   state_nx = S_REQ;
      endcase
    end else begin
      if (br_flag) begin
        pending_nx        = 1'b1;
        pending_target_nx = br_target;
      end
      unique case (state)
        S_REQ: begin
          if (!aligned) begin
            if_pc_nx    = pc;
            if_pcp4_nx  = pc + 32'd4;
            if_inst_nx  = 32'h0;
            if_excp_nx  = EXC_ADEL;
            if_valid_nx = 1'b1;
            state_nx    = S_HOLD;
          end else if (ibus_ready) begin
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid) begin
            if_pc_nx    = pc;
            if_pcp4_nx  = pc + 32'd4;
            if_inst_nx  = ibus_rdata;
            if_excp_nx  = EXC_NONE;
            if_valid_nx = 1'b1;
            state_nx    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid_nx = 1'b0;
            state_nx    = S_REQ;
            // A branch arriving while its delay slot is being accepted redirects right away.
            if (br_flag) begin
              pc_nx      = br_target;
              pending_nx = 1'b0;
            end else if (pending) begin
              pc_nx      = pending_target;
              pending_nx = 1'b0;
            end else begin
              pc_nx = pc + 32'd4;
            end
          end
        end
        S_DISCARD: begin
          if (ibus_rvalid) state_nx = S_REQ;
        end
        default: state_nx = S_REQ;
      endcase
    end
  end

endmodule
